// File: rtl/pinput_sync_array.sv
// Configurable array of pad input conditioners: per-channel synchronizer, optional
// glitch filter, inversion and edge detection, configured through a serial chain.
module pinput_sync_array #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_CH-1:0] gfpga_pad_A2F,
  output logic [NUM_CH-1:0] gfpga_pad_mode_o,
  output logic [NUM_CH-1:0] fpga_in_o,
  output logic [NUM_CH-1:0] fpga_rise_o,
  output logic [NUM_CH-1:0] fpga_fall_o
);

  localparam int CW = 3 * NUM_CH;
  // Count value at which the next differing sample completes a MAXC-long run.
  localparam logic [FILT_W-1:0] LAST = FILT_W'((2 ** FILT_W) - 2);

  logic [CW-1:0] cfg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (cfg_en) begin
      cfg <= {cfg[CW-2:0], ccff_head};
    end
  end

  assign ccff_tail = cfg[CW-1];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [1:0]             mode;
      logic                   inv;
      logic [SYNC_STAGES-1:0] sync_chain;
      logic                   sync_bit;
      logic                   stable;
      logic [FILT_W-1:0]      count;
      logic                   prev;
      logic                   in_val;

      assign mode     = cfg[3*gi+2 -: 2];
      assign inv      = cfg[3*gi];
      assign sync_bit = sync_chain[SYNC_STAGES-1];

      assign gfpga_pad_mode_o[gi] = |mode;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_chain <= '0;
        end else begin
          sync_chain <= {sync_chain[SYNC_STAGES-2:0], gfpga_pad_A2F[gi]};
        end
      end

      // Filter state only runs in mode 11 with the chain idle; otherwise it is parked at 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stable <= 1'b0;
          count  <= '0;
        end else if (cfg_en || mode != 2'b11) begin
          stable <= 1'b0;
          count  <= '0;
        end else if (sync_bit == stable) begin
          count <= '0;
        end else if (count == LAST) begin
          stable <= ~stable;
          count  <= '0;
        end else begin
          count <= count + FILT_W'(1);
        end
      end

      always_comb begin
        in_val = 1'b0;
        if (!cfg_en) begin
          case (mode)
            2'b01:   in_val = gfpga_pad_A2F[gi] ^ inv;
            2'b10:   in_val = sync_bit ^ inv;
            2'b11:   in_val = stable ^ inv;
            default: in_val = 1'b0;
          endcase
        end
      end

      assign fpga_in_o[gi] = in_val;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev <= 1'b0;
        end else if (cfg_en || !mode[1]) begin
          prev <= 1'b0;
        end else begin
          prev <= in_val;
        end
      end

      // Edges are only meaningful for the registered paths; the direct path has none.
      assign fpga_rise_o[gi] = (mode[1] && !cfg_en) ? (in_val & ~prev) : 1'b0;
      assign fpga_fall_o[gi] = (mode[1] && !cfg_en) ? (~in_val & prev) : 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_pinput_sync_array.sv
// Directed self-checking bench for pinput_sync_array with four channels and
// default synchronizer depth and filter width.
module tb_pinput_sync_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_en;
  logic       ccff_head;
  logic       ccff_tail;
  logic [3:0] pad;
  logic [3:0] mode_o;
  logic [3:0] in_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;

  int checks = 0;
  int errors = 0;
  logic [11:0] cur_cfg = '0;

  pinput_sync_array #(.NUM_CH(4), .SYNC_STAGES(2), .FILT_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_en           (cfg_en),
    .ccff_head        (ccff_head),
    .ccff_tail        (ccff_tail),
    .gfpga_pad_A2F    (pad),
    .gfpga_pad_mode_o (mode_o),
    .fpga_in_o        (in_o),
    .fpga_rise_o      (rise_o),
    .fpga_fall_o      (fall_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_mode(input logic [11:0] v);
    logic [3:0] m;
    for (int k = 0; k < 4; k++) m[k] = v[3*k+2] | v[3*k+1];
    return m;
  endfunction

  // Shift a full 12-bit word MSB first; tail must replay the previous word.
  task automatic shift_cfg(input logic [11:0] val, input bit tog);
    for (int i = 11; i >= 0; i--) begin
      ccff_head = val[i];
      cfg_en    = 1'b1;
      if (tog) pad[0] = (i < 3) ? 1'b1 : ~pad[0];
      #1;
      chk("tail_replay", {31'd0, ccff_tail}, {31'd0, cur_cfg[i]});
      step;
      chk("shift_in_zero", {28'd0, in_o}, 32'd0);
      chk("shift_edges_zero", {24'd0, rise_o, fall_o}, 32'd0);
    end
    cfg_en    = 1'b0;
    ccff_head = 1'b0;
    cur_cfg   = val;
    #1;
    chk("mode_decode", {28'd0, mode_o}, {28'd0, exp_mode(val)});
  endtask

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; ccff_head = 1'b0; pad = 4'b0000;
    #1;
    chk("reset_mode", {28'd0, mode_o}, 32'd0);
    chk("reset_out", {20'd0, in_o, rise_o, fall_o}, 32'd0);
    chk("reset_tail", {31'd0, ccff_tail}, 32'd0);
    step; step;
    rst_n = 1'b1;
    step;
    chk("post_reset_out", {16'd0, mode_o, in_o, rise_o, fall_o}, 32'd0);

    // Configuration chain and decode
    shift_cfg(12'b000_011_110_101, 1'b0);
    shift_cfg(12'b100_000_010_111, 1'b0);
    chk("tail_after_shift", {31'd0, ccff_tail}, 32'd1);

    // Mode 10, inv=0 on channel 0
    shift_cfg(12'b000_000_000_100, 1'b0);
    pad[0] = 1'b1;
    step; chk("m10_rise_lat1", {30'd0, in_o[0], rise_o[0]}, 32'd0);
    step; chk("m10_rise_lat2", {30'd0, in_o[0], rise_o[0]}, 32'd3);
    step; chk("m10_rise_end", {30'd0, in_o[0], rise_o[0]}, 32'd2);
    pad[0] = 1'b0;
    step; chk("m10_fall_lat1", {30'd0, in_o[0], fall_o[0]}, 32'd2);
    step; chk("m10_fall_lat2", {30'd0, in_o[0], fall_o[0]}, 32'd1);
    step; chk("m10_fall_end", {30'd0, in_o[0], fall_o[0]}, 32'd0);

    // Mode 11: 14-sample glitch rejected, 15-sample run accepted
    shift_cfg(12'b000_000_000_110, 1'b0);
    pad[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step;
      if (i == 14) pad[0] = 1'b0;
      chk("m11_glitch", {30'd0, in_o[0], rise_o[0]}, 32'd0);
    end
    pad[0] = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      step;
      if (i == 15) pad[0] = 1'b0;
      chk("m11_run", {30'd0, in_o[0], rise_o[0]}, {30'd0, (i >= 17), (i == 17)});
    end

    // Mode 01 inv=1 on channel 2, mode 00 on channel 3
    shift_cfg(12'b000_011_000_000, 1'b0);
    pad = 4'b0000; #1;
    chk("m01_inv_low", {31'd0, in_o[2]}, 32'd1);
    pad = 4'b1100; #1;
    chk("m01_inv_high", {31'd0, in_o[2]}, 32'd0);
    chk("m00_out", {31'd0, in_o[3]}, 32'd0);
    step;
    pad = 4'b1000; #1;
    chk("m01_comb", {31'd0, in_o[2]}, 32'd1);
    step;
    chk("m01_no_edges", {24'd0, rise_o, fall_o}, 32'd0);

    // Asynchronous reset mid filter count
    pad = 4'b0000;
    shift_cfg(12'b000_000_000_110, 1'b0);
    pad[0] = 1'b1;
    for (int i = 0; i < 8; i++) step;
    #2 rst_n = 1'b0; #1;
    chk("rst_mid_filter", {18'd0, ccff_tail, 1'b0, mode_o, in_o, rise_o, fall_o}, 32'd0);
    step;
    rst_n = 1'b1;
    step;
    chk("rst_release", {16'd0, mode_o, in_o, rise_o, fall_o}, 32'd0);
    cur_cfg = '0;

    // Asynchronous reset mid shift
    pad = 4'b0000;
    shift_cfg(12'hFFF, 1'b0);
    cfg_en = 1'b1; ccff_head = 1'b0;
    step; step;
    #2 rst_n = 1'b0; #1;
    chk("rst_mid_shift", {27'd0, ccff_tail, mode_o}, 32'd0);
    cfg_en = 1'b0;
    step;
    rst_n = 1'b1;
    step; step;
    chk("rst_shift_release", {15'd0, ccff_tail, mode_o, in_o, rise_o, fall_o}, 32'd0);
    cur_cfg = '0;

    // Reconfigure channel 1 while channel 0's pad toggles; filter restarts clean
    shift_cfg(12'b000_000_000_110, 1'b0);
    pad[0] = 1'b1;
    for (int i = 0; i < 8; i++) step;
    shift_cfg(12'b000_000_101_110, 1'b1);
    chk("ch1_first_rise", {30'd0, in_o[1], rise_o[1]}, 32'd3);
    for (int i = 1; i <= 16; i++) begin
      step;
      if (i == 1) chk("ch1_rise_once", {30'd0, in_o[1], rise_o[1]}, 32'd2);
      chk("ch0_restart", {30'd0, in_o[0], rise_o[0]}, {30'd0, (i >= 15), (i == 15)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pinput_sync_array.md
PINPUT_SYNC_ARRAY -- requirements
Module: pinput_sync_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent pad input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flop depth per channel (>=2).
REQ-003 SHALL have parameter FILT_W, default 4, meaning glitch-filter counter width; threshold MAXC = 2^FILT_W-1 cycles.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state is in this domain.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port cfg_en  input  1  meaning configuration-chain shift enable.
REQ-007 SHALL have port ccff_head  input  1  meaning configuration serial data in.
REQ-008 SHALL have port ccff_tail  output  1  meaning configuration serial data out, equal to cfg[3*NUM_CH-1].
REQ-009 SHALL have port gfpga_pad_A2F  input  NUM_CH  meaning asynchronous SoC-side pad inputs.
REQ-010 SHALL have port gfpga_pad_mode_o  output  NUM_CH  meaning per-channel input-enable status to the pad.
REQ-011 SHALL have port fpga_in_o  output  NUM_CH  meaning conditioned value to the fabric.
REQ-012 SHALL have ports fpga_rise_o and fpga_fall_o, both  output  NUM_CH, meaning one-cycle edge pulses of fpga_in_o.

Function
REQ-013 SHALL hold a config register cfg[3*NUM_CH-1:0]; on a clk edge with cfg_en=1, cfg <= {cfg[3*NUM_CH-2:0], ccff_head}; with cfg_en=0, cfg holds.
REQ-014 SHALL decode channel k from cfg[3k+2:3k] = {mode[1:0], inv}; mode 00 disabled, 01 direct, 10 synchronized, 11 synchronized+filtered.
REQ-015 SHALL drive gfpga_pad_mode_o[k] = 1 when mode != 00, combinationally from cfg, including while cfg_en=1.
REQ-016 SHALL run a SYNC_STAGES-deep synchronizer per channel continuously, independent of mode and cfg_en; its last stage is sync[k].
REQ-017 Mode 00: fpga_in_o[k] SHALL be 0.
REQ-018 Mode 01: fpga_in_o[k] SHALL be gfpga_pad_A2F[k] XOR inv, purely combinational with zero latency.
REQ-019 Mode 10: fpga_in_o[k] SHALL be sync[k] XOR inv, i.e. a pad change appears after SYNC_STAGES clk edges.
REQ-020 Mode 11: each channel SHALL keep a stable bit s[k] and a FILT_W-bit counter c[k]; fpga_in_o[k] = s[k] XOR inv.
REQ-021 Filter: if sync[k]==s[k], c <= 0; else if c==MAXC-1, s <= ~s and c <= 0; else c <= c+1; s therefore flips after exactly MAXC consecutive differing samples.
REQ-022 Filter: a differing run shorter than MAXC cycles SHALL leave s unchanged and clear c on the first matching sample; c SHALL never wrap.
REQ-023 In modes 00, 01 and 10, s[k] and c[k] SHALL be held at 0.
REQ-024 SHALL register prev[k] = fpga_in_o[k] each cycle in modes 10/11; fpga_rise_o[k] = fpga_in_o & ~prev, fpga_fall_o[k] = ~fpga_in_o & prev.
REQ-025 In modes 00/01, fpga_rise_o and fpga_fall_o SHALL be 0 and prev[k] SHALL be held at 0.
REQ-026 While cfg_en=1: fpga_in_o, fpga_rise_o and fpga_fall_o SHALL be forced to 0 for all channels, and s, c and prev SHALL be cleared.
REQ-027 On the first cycle after cfg_en falls, edges SHALL be computed against prev=0; e.g. mode 10 with inv=1 and pad low gives one rise pulse. This is required behaviour.
REQ-028 Channels SHALL be fully independent; a config change on one channel SHALL not disturb another channel's s, c or prev.

Reset
REQ-029 While rst_n=0, SHALL asynchronously clear cfg, all synchronizer stages, s, c and prev.
REQ-030 During and after reset, all channels SHALL read as mode 00: gfpga_pad_mode_o=0, fpga_in_o=0, edge outputs 0 and ccff_tail=0.
REQ-031 Reset deassertion SHALL take effect on the next clk edge with no spurious edge pulse.

Verification
REQ-032 Config: NUM_CH=4; shift 12 bits with cfg_en=1 -> cfg matches the shifted pattern; ccff_tail replays the bits after 12 cycles; gfpga_pad_mode_o reflects the decoded modes.
REQ-033 Mode 10, inv=0: pad 0->1 -> fpga_in_o rises exactly 2 edges later; fpga_rise_o pulses exactly 1 cycle on that edge; 1->0 gives the matching fall pulse.
REQ-034 Mode 11, FILT_W=4: a 14-cycle high glitch at sync -> no output change or pulse; a 15-cycle high run -> s flips on the 15th sample with one rise pulse.
REQ-035 Mode 01, inv=1 -> fpga_in_o = ~pad combinationally, no edge pulses; mode 00 -> output 0 while gfpga_pad_mode_o=0.
REQ-036 Assert rst_n=0 mid-filter-count and mid-shift -> all outputs 0 immediately; after release, mode 00 everywhere, c=0, no pulses.
REQ-037 Reconfigure channel 1 with cfg_en while channel 0's pad toggles -> all outputs held 0 during cfg_en; channel 0 filter restarts from s=0 afterwards.
